// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants and the ARP receive state type.
package eth_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'd6;
  localparam logic [7:0]  ARP_PLEN       = 8'd4;
  localparam logic [15:0] ARP_OP_REQUEST = 16'd1;
  localparam logic [15:0] ARP_OP_REPLY   = 16'd2;
  localparam logic [4:0]  ARP_BODY_LEN   = 5'd28;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PARSE,
    ST_WAIT_END,
    ST_CRC,
    ST_DONE,
    ST_ERR,
    ST_DROP
  } ARP_RX_STATE;

  // True when byte b at body offset idx is acceptable for an IPv4-over-Ethernet
  // ARP header. Offsets outside the fixed header/opcode always pass.
  function automatic logic arp_hdr_byte_ok(input logic [4:0] idx, input logic [7:0] b);
    logic ok;
    ok = 1'b1;
    case (idx)
      5'd0: ok = (b == ARP_HTYPE_ETH[15:8]);
      5'd1: ok = (b == ARP_HTYPE_ETH[7:0]);
      5'd2: ok = (b == ARP_PTYPE_IPV4[15:8]);
      5'd3: ok = (b == ARP_PTYPE_IPV4[7:0]);
      5'd4: ok = (b == ARP_HLEN);
      5'd5: ok = (b == ARP_PLEN);
      5'd6: ok = (b == ARP_OP_REQUEST[15:8]);
      5'd7: ok = (b == ARP_OP_REQUEST[7:0]) || (b == ARP_OP_REPLY[7:0]);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/arp_decode.sv
// ARP body parser sitting behind the MAC receive decoder. Captures the
// 28-byte ARP body, validates the header, and publishes the result only
// after the frame closes with a good FCS.
module arp_decode
  import eth_pkg::*;
#(
  parameter logic [31:0] IP_ADDR   = 32'hC0A8_0164,
  parameter bit          CHECK_SHA = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  input  logic        arp_decode_valid,
  input  logic        crc_err,
  input  logic [47:0] sa,
  output logic        arp_valid,
  output logic        arp_err,
  output logic [15:0] arp_oper,
  output logic [47:0] sender_mac,
  output logic [31:0] sender_ip,
  output logic [31:0] target_ip,
  output logic        req_for_us
);

  ARP_RX_STATE state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        adv_prev_q;
  logic        sha_ok_q, sha_ok_d;
  logic        capture;
  logic        start;

  // Working registers, filled byte by byte while parsing.
  logic [15:0] oper_w_q, oper_w_d;
  logic [47:0] sha_w_q, sha_w_d;
  logic [31:0] spa_w_q, spa_w_d;
  logic [31:0] tpa_w_q, tpa_w_d;
  logic        req_for_us_w;

  // Published result registers, touched only on entry to DONE.
  logic        load_out;
  logic [15:0] arp_oper_q;
  logic [47:0] sender_mac_q;
  logic [31:0] sender_ip_q;
  logic [31:0] target_ip_q;
  logic        req_for_us_q;

  // A frame starts only on a rising arp_decode_valid, so a frame interrupted
  // by reset is not picked up again mid-payload.
  assign start        = rx_dv && arp_decode_valid && !adv_prev_q;
  assign req_for_us_w = (oper_w_q == ARP_OP_REQUEST) && (tpa_w_q == IP_ADDR);

  // Next-state, byte index and strobe decisions.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sha_ok_d = sha_ok_q;
    capture  = 1'b0;
    load_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = 5'd0;
        if (start) begin
          capture = 1'b1;
          idx_d   = 5'd1;
          state_d = arp_hdr_byte_ok(5'd0, rxd) ? ST_PARSE : ST_DROP;
        end
      end
      ST_PARSE: begin
        if (!rx_dv || !arp_decode_valid) begin
          state_d = ST_ERR;
        end else begin
          capture = 1'b1;
          if (!arp_hdr_byte_ok(idx_q, rxd)) begin
            state_d = ST_DROP;
          end else if (idx_q == ARP_BODY_LEN - 5'd1) begin
            idx_d    = ARP_BODY_LEN;
            sha_ok_d = (sha_w_q == sa);
            state_d  = ST_WAIT_END;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      ST_WAIT_END: begin
        if (!rx_dv) begin
          state_d = ST_CRC;
        end else if (!arp_decode_valid) begin
          state_d = ST_ERR;
        end
      end
      ST_CRC: begin
        if (crc_err || (CHECK_SHA && !sha_ok_q)) begin
          state_d = ST_ERR;
        end else begin
          state_d  = ST_DONE;
          load_out = 1'b1;
        end
      end
      ST_DONE: begin
        idx_d   = 5'd0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        idx_d   = 5'd0;
        state_d = ST_IDLE;
      end
      ST_DROP: begin
        if (!rx_dv) begin
          state_d = ST_ERR;
        end
      end
      default: begin
        idx_d   = 5'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Index-decoded byte capture: each field shifts in big-endian order.
  always_comb begin
    oper_w_d = oper_w_q;
    sha_w_d  = sha_w_q;
    spa_w_d  = spa_w_q;
    tpa_w_d  = tpa_w_q;
    if (capture) begin
      if (idx_q >= 5'd6 && idx_q <= 5'd7) begin
        oper_w_d = {oper_w_q[7:0], rxd};
      end
      if (idx_q >= 5'd8 && idx_q <= 5'd13) begin
        sha_w_d = {sha_w_q[39:0], rxd};
      end
      if (idx_q >= 5'd14 && idx_q <= 5'd17) begin
        spa_w_d = {spa_w_q[23:0], rxd};
      end
      if (idx_q >= 5'd24 && idx_q <= 5'd27) begin
        tpa_w_d = {tpa_w_q[23:0], rxd};
      end
    end
  end

  // State, index and working-register flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 5'd0;
      adv_prev_q <= 1'b1;
      sha_ok_q   <= 1'b0;
      oper_w_q   <= '0;
      sha_w_q    <= '0;
      spa_w_q    <= '0;
      tpa_w_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      adv_prev_q <= arp_decode_valid;
      sha_ok_q   <= sha_ok_d;
      oper_w_q   <= oper_w_d;
      sha_w_q    <= sha_w_d;
      spa_w_q    <= spa_w_d;
      tpa_w_q    <= tpa_w_d;
    end
  end

  // Result registers hold the last good packet until the next one completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arp_oper_q   <= '0;
      sender_mac_q <= '0;
      sender_ip_q  <= '0;
      target_ip_q  <= '0;
      req_for_us_q <= 1'b0;
    end else if (load_out) begin
      arp_oper_q   <= oper_w_q;
      sender_mac_q <= sha_w_q;
      sender_ip_q  <= spa_w_q;
      target_ip_q  <= tpa_w_q;
      req_for_us_q <= req_for_us_w;
    end
  end

  assign arp_valid  = (state_q == ST_DONE);
  assign arp_err    = (state_q == ST_ERR);
  assign arp_oper   = arp_oper_q;
  assign sender_mac = sender_mac_q;
  assign sender_ip  = sender_ip_q;
  assign target_ip  = target_ip_q;
  assign req_for_us = req_for_us_q;

endmodule
